// File: rtl/eq_pkg.sv
// eq_pkg: shared definitions for the equalizer gain path.
//   NUM_BANDS_DEFAULT / GAIN_W_DEFAULT : default band count and gain width
//   gain_t                             : one gain code, unsigned Q2.6 (64 = unity)
//   sched_state_t                      : gain ramp scheduler states
package eq_pkg;

    localparam int NUM_BANDS_DEFAULT = 3;
    localparam int GAIN_W_DEFAULT    = 8;

    typedef logic [GAIN_W_DEFAULT-1:0] gain_t;

    typedef enum logic {
        IDLE,
        SCAN
    } sched_state_t;

endpackage

// File: rtl/gain_step.sv
// gain_step: combinational one-step ramp function.
// Moves current toward target by at most STEP codes.
// It lands exactly on target when within STEP, so it never overshoots or wraps.
//   current : gain currently applied
//   target  : effective target gain
//   next    : gain after one step
module gain_step #(
    parameter int GAIN_W = 8,
    parameter int STEP   = 1
) (
    input  logic [GAIN_W-1:0] current,
    input  logic [GAIN_W-1:0] target,
    output logic [GAIN_W-1:0] next
);

    localparam int unsigned       STEP_U = STEP;
    localparam logic [GAIN_W-1:0] STEP_G = GAIN_W'(STEP);

    logic signed [GAIN_W:0] diff;
    logic        [GAIN_W:0] mag;

    always_comb begin
        diff = $signed({1'b0, target}) - $signed({1'b0, current});
        mag  = diff[GAIN_W] ? $unsigned(-diff) : $unsigned(diff);
        if ({{(31-GAIN_W){1'b0}}, mag} <= STEP_U) begin
            next = target;
        end else if (!diff[GAIN_W]) begin
            next = current + STEP_G;
        end else begin
            next = current - STEP_G;
        end
    end

endmodule

// File: rtl/gain_ramp_scheduler.sv
// gain_ramp_scheduler: holds per-band target gains.
// After each sample tick it walks the bands one per clock, moving each applied
// gain one bounded step toward its effective target.
// Optional feature macro: EQ_MUTE_EN (adds the mute input; mute ramps all bands to 0).
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   sample_tick   : one-cycle pulse per audio sample, starts a scan
//   target_valid  : one-cycle pulse, loads target_gain into the target registers
//   target_gain   : new per-band targets
//   mute          : (EQ_MUTE_EN only) effective targets forced to 0 while high
//   gain_out      : applied per-band gains
//   busy          : scan in progress
//   settled       : every gain_out equals its effective target
//   overrun       : sticky, a sample_tick arrived while busy
module gain_ramp_scheduler
    import eq_pkg::*;
#(
    parameter int NUM_BANDS  = NUM_BANDS_DEFAULT,
    parameter int GAIN_W     = GAIN_W_DEFAULT,
    parameter int STEP       = 1,
    parameter int RESET_GAIN = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_tick,
    input  logic              target_valid,
    input  logic [GAIN_W-1:0] target_gain [0:NUM_BANDS-1],
`ifdef EQ_MUTE_EN
    input  logic              mute,
`endif
    output logic [GAIN_W-1:0] gain_out [0:NUM_BANDS-1],
    output logic              busy,
    output logic              settled,
    output logic              overrun
);

    localparam int                IDX_W  = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam logic [GAIN_W-1:0] RST_G  = GAIN_W'(RESET_GAIN);
    localparam logic [IDX_W-1:0]  LAST_I = IDX_W'(NUM_BANDS - 1);

    sched_state_t      state, state_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [GAIN_W-1:0] tgt [0:NUM_BANDS-1];
    logic [GAIN_W-1:0] eff [0:NUM_BANDS-1];
    logic [GAIN_W-1:0] cur_sel, eff_sel, step_next;
    logic              scan_end;
    logic              all_match;
    logic              mute_changed;

`ifdef EQ_MUTE_EN
    logic mute_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) mute_q <= 1'b0;
        else       mute_q <= mute;
    end

    assign mute_changed = mute ^ mute_q;
`else
    assign mute_changed = 1'b0;
`endif

    always_comb begin
        for (int unsigned k = 0; k < NUM_BANDS; k++) begin
            eff[k] = tgt[k];
`ifdef EQ_MUTE_EN
            if (mute) eff[k] = '0;
`endif
        end
    end

    // Single shared step unit, steered to the band under idx.
    assign cur_sel = gain_out[idx];
    assign eff_sel = eff[idx];

    gain_step #(
        .GAIN_W (GAIN_W),
        .STEP   (STEP)
    ) u_step (
        .current (cur_sel),
        .target  (eff_sel),
        .next    (step_next)
    );

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        scan_end  = 1'b0;
        case (state)
            IDLE: begin
                if (sample_tick) begin
                    state_nxt = SCAN;
                    idx_nxt   = '0;
                end
            end
            SCAN: begin
                if (idx == LAST_I) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                    scan_end  = 1'b1;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // Settled is judged on the post-edge gains, so the band being written
    // this cycle is compared using the step unit result.
    always_comb begin
        all_match = 1'b1;
        for (int unsigned k = 0; k < NUM_BANDS; k++) begin
            if (state == SCAN && idx == IDX_W'(k)) begin
                if (step_next != eff[k]) all_match = 1'b0;
            end else begin
                if (gain_out[k] != eff[k]) all_match = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            busy  <= (state_nxt == SCAN);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < NUM_BANDS; k++) begin
                tgt[k]      <= RST_G;
                gain_out[k] <= RST_G;
            end
            settled <= 1'b1;
            overrun <= 1'b0;
        end else begin
            if (target_valid) tgt <= target_gain;
            if (state == SCAN) gain_out[idx] <= step_next;
            if (sample_tick && state == SCAN) overrun <= 1'b1;
            // A target or mute change invalidates the scan result on the same edge.
            if (target_valid || mute_changed) settled <= 1'b0;
            else if (scan_end)                settled <= all_match;
        end
    end

endmodule

// File: tb/tb_gain_ramp_scheduler.sv
// tb_gain_ramp_scheduler: scoreboard bench.
// It drives two instances, one with STEP=1 (unit 0) and one with STEP=4 (unit 1).
// When a tick is driven, the expected post-scan gains are computed by a small model and pushed.
// They are popped and compared once the scan ends.
module tb_gain_ramp_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_in  [2];
    logic       tv_in    [2];
    logic [7:0] ta [0:2];
    logic [7:0] tb [0:2];
    logic [7:0] ga [0:2];
    logic [7:0] gb [0:2];
    logic       busy_o    [2];
    logic       settled_o [2];
    logic       overrun_o [2];
`ifdef EQ_MUTE_EN
    logic       mute_in [2];
`endif

    always #5 clk = ~clk;

    gain_ramp_scheduler #(.NUM_BANDS(3), .GAIN_W(8), .STEP(1), .RESET_GAIN(64)) dut_a (
        .clk          (clk),
        .reset        (reset),
        .sample_tick  (tick_in[0]),
        .target_valid (tv_in[0]),
        .target_gain  (ta),
`ifdef EQ_MUTE_EN
        .mute         (mute_in[0]),
`endif
        .gain_out     (ga),
        .busy         (busy_o[0]),
        .settled      (settled_o[0]),
        .overrun      (overrun_o[0])
    );

    gain_ramp_scheduler #(.NUM_BANDS(3), .GAIN_W(8), .STEP(4), .RESET_GAIN(64)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .sample_tick  (tick_in[1]),
        .target_valid (tv_in[1]),
        .target_gain  (tb),
`ifdef EQ_MUTE_EN
        .mute         (mute_in[1]),
`endif
        .gain_out     (gb),
        .busy         (busy_o[1]),
        .settled      (settled_o[1]),
        .overrun      (overrun_o[1])
    );

    typedef struct {
        int          u;
        logic [23:0] g;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   mg    [2][3];
    int   mt    [2][3];
    int   mstep [2] = '{1, 4};
    bit   mmute [2] = '{1'b0, 1'b0};

    function automatic logic [23:0] gains(int u);
        if (u == 0) return {ga[0], ga[1], ga[2]};
        return {gb[0], gb[1], gb[2]};
    endfunction

    function automatic int step_model(int c, int t, int s);
        int d = t - c;
        if (d <= s && d >= -s) return t;
        if (d > 0) return c + s;
        return c - s;
    endfunction

    function automatic logic [23:0] model_gains(int u);
        return {mg[u][0][7:0], mg[u][1][7:0], mg[u][2][7:0]};
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < 3; k++) begin
                mg[u][k] = 64;
                mt[u][k] = 64;
            end
            mmute[u] = 1'b0;
        end
        sb.delete();
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic load(int u, int a, int b, int c);
        if (u == 0) begin ta[0] = 8'(a); ta[1] = 8'(b); ta[2] = 8'(c); end
        else        begin tb[0] = 8'(a); tb[1] = 8'(b); tb[2] = 8'(c); end
        tv_in[u] = 1'b1;
        mt[u][0] = a; mt[u][1] = b; mt[u][2] = c;
        @(negedge clk);
        tv_in[u] = 1'b0;
    endtask

    // Drives a tick at the current negedge, pushes the expected post-scan
    // gains, and returns at the first negedge with busy low (or timeout).
    task automatic do_scan(int u, output bit timed_out);
        exp_t e;
        tick_in[u] = 1'b1;
        for (int k = 0; k < 3; k++)
            mg[u][k] = step_model(mg[u][k], mmute[u] ? 0 : mt[u][k], mstep[u]);
        e.u = u;
        e.g = model_gains(u);
        sb.push_back(e);
        @(negedge clk);
        tick_in[u] = 1'b0;
        timed_out = 1'b1;
        for (int n = 0; n < 10; n++) begin
            if (busy_o[u] == 1'b0) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (gains(u) !== 24'h404040) begin
                errors++;
                $display("FAIL reset_gain u%0d got=%h exp=404040", u, gains(u));
            end
            checks++;
            if (settled_o[u] !== 1'b1 || busy_o[u] !== 1'b0 || overrun_o[u] !== 1'b0) begin
                errors++;
                $display("FAIL reset_flags u%0d got s/b/o=%b%b%b exp=100", u,
                         settled_o[u], busy_o[u], overrun_o[u]);
            end
        end
    endtask

    task automatic test_ramp_step1();
        bit   to;
        exp_t e;
        load(0, 70, 64, 60);
        checks++;
        if (settled_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL step1_settled_clear got=%b exp=0", settled_o[0]);
        end
        for (int i = 1; i <= 6; i++) begin
            do_scan(0, to);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL step1_timeout scan=%0d busy still high", i);
            end
            e = sb.pop_front();
            checks++;
            if (gains(e.u) !== e.g) begin
                errors++;
                $display("FAIL step1_scan%0d got=%h exp=%h", i, gains(e.u), e.g);
            end
            if (i == 3) begin
                checks++;
                if (gains(0) !== {8'd67, 8'd64, 8'd61}) begin
                    errors++;
                    $display("FAIL step1_after3 got=%h exp=%h", gains(0), {8'd67, 8'd64, 8'd61});
                end
            end
            if (i < 6) begin
                checks++;
                if (settled_o[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL step1_not_settled scan=%0d got=%b exp=0", i, settled_o[0]);
                end
            end
            repeat (4) @(negedge clk);
        end
        checks++;
        if (gains(0) !== {8'd70, 8'd64, 8'd60} || settled_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL step1_final got=%h settled=%b exp=%h settled=1",
                     gains(0), settled_o[0], {8'd70, 8'd64, 8'd60});
        end
    endtask

    task automatic test_step4_bounds();
        bit   to;
        exp_t e;
        load(1, 66, 64, 64);
        do_scan(1, to);
        e = sb.pop_front();
        checks++;
        if (to || gains(1) !== e.g || gb[0] !== 8'd66) begin
            errors++;
            $display("FAIL step4_no_overshoot got=%h exp=%h timeout=%b", gains(1), e.g, to);
        end
        load(1, 0, 64, 64);
        for (int i = 1; i <= 18; i++) begin
            do_scan(1, to);
            e = sb.pop_front();
            checks++;
            if (to || gains(1) !== e.g) begin
                errors++;
                $display("FAIL step4_down scan=%0d got=%h exp=%h timeout=%b", i, gains(1), e.g, to);
            end
            repeat (2) @(negedge clk);
        end
        checks++;
        if (gb[0] !== 8'd0 || settled_o[1] !== 1'b1) begin
            errors++;
            $display("FAIL step4_floor got=%0d settled=%b exp=0 settled=1", gb[0], settled_o[1]);
        end
    endtask

    // Ticks every NUM_BANDS+1 clocks must never flag overrun.
    task automatic test_back_to_back();
        bit   to;
        exp_t e;
        load(1, 40, 90, 64);
        for (int i = 1; i <= 5; i++) begin
            do_scan(1, to);
            e = sb.pop_front();
            checks++;
            if (to || gains(1) !== e.g) begin
                errors++;
                $display("FAIL b2b scan=%0d got=%h exp=%h timeout=%b", i, gains(1), e.g, to);
            end
        end
        checks++;
        if (overrun_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_overrun got=%b exp=0", overrun_o[1]);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_overrun();
        exp_t e;
        load(0, 80, 50, 64);
        tick_in[0] = 1'b1;
        for (int k = 0; k < 3; k++)
            mg[0][k] = step_model(mg[0][k], mt[0][k], mstep[0]);
        e.u = 0;
        e.g = model_gains(0);
        sb.push_back(e);
        @(negedge clk);           // edge E done, tick still high for E+1
        checks++;
        if (busy_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL ovr_busy_E got=%b exp=1", busy_o[0]);
        end
        @(negedge clk);           // edge E+1 done
        tick_in[0] = 1'b0;
        checks++;
        if (overrun_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL ovr_set got=%b exp=1", overrun_o[0]);
        end
        @(negedge clk);           // E+2
        checks++;
        if (busy_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL ovr_busy_E2 got=%b exp=1", busy_o[0]);
        end
        @(negedge clk);           // E+3
        checks++;
        if (busy_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL ovr_busy_E3 got=%b exp=0", busy_o[0]);
        end
        e = sb.pop_front();
        checks++;
        if (gains(0) !== e.g) begin
            errors++;
            $display("FAIL ovr_one_scan got=%h exp=%h", gains(0), e.g);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (busy_o[0] !== 1'b0 || overrun_o[0] !== 1'b1 || gains(0) !== model_gains(0)) begin
            errors++;
            $display("FAIL ovr_sticky got busy=%b ovr=%b g=%h exp busy=0 ovr=1 g=%h",
                     busy_o[0], overrun_o[0], gains(0), model_gains(0));
        end
    endtask

    task automatic test_reset_midscan();
        bit to;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        load(1, 80, 80, 80);
        tick_in[1] = 1'b1;
        @(negedge clk);           // edge E done
        tick_in[1] = 1'b0;
        @(negedge clk);           // edge E+1 done: band 0 stepped
        checks++;
        if (gb[0] !== 8'd68 || gb[1] !== 8'd64) begin
            errors++;
            $display("FAIL midscan_partial got=%0d,%0d exp=68,64", gb[0], gb[1]);
        end
        #2 reset = 1'b1;          // before edge E+2
        #1;
        checks++;
        if (gains(1) !== 24'h404040 || busy_o[1] !== 1'b0 || settled_o[1] !== 1'b1) begin
            errors++;
            $display("FAIL midscan_reset got=%h busy=%b settled=%b exp=404040 busy=0 settled=1",
                     gains(1), busy_o[1], settled_o[1]);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        // Scan restarts from IDLE with reset targets: gains stay at 64.
        do_scan(1, to);
        checks++;
        if (to || gains(1) !== sb.pop_front().g) begin
            errors++;
            $display("FAIL midscan_restart got=%h exp=404040 timeout=%b", gains(1), to);
        end
        checks++;
        if (overrun_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL midscan_ovr_clear got=%b exp=0", overrun_o[0]);
        end
    endtask

`ifdef EQ_MUTE_EN
    task automatic test_mute();
        bit   to;
        exp_t e;
        mute_in[1] = 1'b1;
        mmute[1]   = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            do_scan(1, to);
            e = sb.pop_front();
            checks++;
            if (to || gains(1) !== e.g) begin
                errors++;
                $display("FAIL mute_down scan=%0d got=%h exp=%h timeout=%b", i, gains(1), e.g, to);
            end
            repeat (2) @(negedge clk);
        end
        checks++;
        if (gains(1) !== 24'h000000 || settled_o[1] !== 1'b1) begin
            errors++;
            $display("FAIL mute_zero got=%h settled=%b exp=000000 settled=1", gains(1), settled_o[1]);
        end
        mute_in[1] = 1'b0;
        mmute[1]   = 1'b0;
        @(negedge clk);
        checks++;
        if (settled_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL mute_release_settled got=%b exp=0", settled_o[1]);
        end
        for (int i = 1; i <= 16; i++) begin
            do_scan(1, to);
            e = sb.pop_front();
            checks++;
            if (to || gains(1) !== e.g) begin
                errors++;
                $display("FAIL mute_up scan=%0d got=%h exp=%h timeout=%b", i, gains(1), e.g, to);
            end
            repeat (2) @(negedge clk);
        end
        checks++;
        if (gains(1) !== 24'h404040 || settled_o[1] !== 1'b1) begin
            errors++;
            $display("FAIL mute_restore got=%h settled=%b exp=404040 settled=1", gains(1), settled_o[1]);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            tick_in[u] = 1'b0;
            tv_in[u]   = 1'b0;
`ifdef EQ_MUTE_EN
            mute_in[u] = 1'b0;
`endif
        end
        for (int k = 0; k < 3; k++) begin
            ta[k] = 8'd64;
            tb[k] = 8'd64;
        end
        model_reset();
        @(negedge clk);

        test_reset();
        test_ramp_step1();
        test_step4_bounds();
        test_back_to_back();
        test_overrun();
        test_reset_midscan();
`ifdef EQ_MUTE_EN
        test_mute();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
